// File: rtl/crc32_stream_ctrl.sv
// Byte-stream CRC-32 sequencer: passes frames through a single output register,
// then either appends the 4-byte FCS (generate) or reports FCS good/bad (check).

// One DATA_WIDTH-bit step of a Galois LFSR; REVERSE=1 shifts LSB-first
// using the bit-reversed polynomial (the usual reflected CRC-32 form).
module crc32_lfsr_step #(
  parameter int                      LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0]   POLY       = 32'h04c11db7,
  parameter bit                      REVERSE    = 1'b1,
  parameter int                      DATA_WIDTH = 8
) (
  input  logic [LFSR_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  logic [LFSR_WIDTH-1:0] rpoly;
  logic [LFSR_WIDTH-1:0] s;
  logic                  fb;

  // bit-serial unrolled update, one polynomial reduction per data bit
  always_comb begin
    rpoly = '0;
    for (int j = 0; j < LFSR_WIDTH; j++) rpoly[j] = POLY[LFSR_WIDTH-1-j];
    s  = state_in;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = s[0] ^ data_in[i];
        s  = s >> 1;
        if (fb) s = s ^ rpoly;
      end else begin
        fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        s  = s << 1;
        if (fb) s = s ^ POLY;
      end
    end
    state_out = s;
  end

endmodule

module crc32_stream_ctrl #(
  parameter logic [31:0] CRC_INIT    = 32'hffffffff,
  parameter logic [31:0] CRC_RESIDUE = 32'hdebb20e3,
  parameter int          LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [31:0]          crc_out,
  output logic                 crc_ok,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 crc_valid
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FCS, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          crc_state, lfsr_out, crc_d, crc_inv;
  logic [LEN_WIDTH-1:0] len_cnt, len_d;
  logic [1:0]           byte_idx;
  logic                 mode_q, mode_eff, mode_d;
  logic                 ld_ok, accept, load, load_last, fcs_load;
  logic [7:0]           load_data, fcs_byte;

  crc32_lfsr_step #(
    .LFSR_WIDTH (32),
    .POLY       (32'h04c11db7),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_lfsr (
    .state_in  (crc_state),
    .data_in   (s_data),
    .state_out (lfsr_out)
  );

  // output register may take a new byte when empty or draining this cycle
  assign ld_ok    = !m_valid || m_ready;
  // mode is only sampled on the first beat; later beats use the latched copy
  assign mode_eff = (state_q == S_IDLE) ? mode : mode_q;
  assign mode_d   = (state_q == S_IDLE && accept) ? mode : mode_q;
  assign crc_d    = accept ? lfsr_out : crc_state;
  assign len_d    = !accept                ? len_cnt :
                    (state_q == S_IDLE)    ? LEN_WIDTH'(1) :
                    (&len_cnt)             ? len_cnt : len_cnt + 1'b1;
  assign crc_inv  = ~crc_state;

  // FCS byte select, LSB byte first
  always_comb begin
    fcs_byte = crc_inv[7:0];
    case (byte_idx)
      2'd0: fcs_byte = crc_inv[7:0];
      2'd1: fcs_byte = crc_inv[15:8];
      2'd2: fcs_byte = crc_inv[23:16];
      2'd3: fcs_byte = crc_inv[31:24];
      default: fcs_byte = crc_inv[7:0];
    endcase
  end

  // next-state, handshake and output-register load selection
  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    load_data = s_data;
    load_last = 1'b0;
    fcs_load  = 1'b0;
    case (state_q)
      S_IDLE, S_DATA: begin
        s_ready = ld_ok && !rst;
        accept  = s_valid && s_ready;
        if (accept) begin
          load      = 1'b1;
          load_last = s_last && mode_eff;
          if (s_last) state_d = mode_eff ? S_DONE : S_FCS;
          else        state_d = S_DATA;
        end
      end
      S_FCS: begin
        if (ld_ok) begin
          load      = 1'b1;
          fcs_load  = 1'b1;
          load_data = fcs_byte;
          load_last = (byte_idx == 2'd3);
          if (byte_idx == 2'd3) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // CRC state, byte counter, latched mode and FCS byte index
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_state <= CRC_INIT;
      len_cnt   <= '0;
      mode_q    <= 1'b0;
      byte_idx  <= 2'd0;
    end else if (state_q == S_DONE) begin
      crc_state <= CRC_INIT;
      len_cnt   <= '0;
      byte_idx  <= 2'd0;
    end else begin
      crc_state <= crc_d;
      len_cnt   <= len_d;
      mode_q    <= mode_d;
      if (fcs_load) byte_idx <= byte_idx + 2'd1;
    end
  end

  // single output register stage; holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= 8'h00;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

  // frame results captured on the way into DONE so they are valid during it
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_valid <= 1'b0;
      crc_out   <= 32'h0;
      crc_ok    <= 1'b0;
      frame_len <= '0;
    end else begin
      crc_valid <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        crc_out   <= ~crc_d;
        crc_ok    <= mode_d && (crc_d == CRC_RESIDUE);
        frame_len <= len_d;
      end
    end
  end

endmodule
